// File: rtl/pa_sched_pkg.sv
// Shared types and default sizes for the phase accumulator sequencer.
package pa_sched_pkg;

  localparam int PA_ACC_W      = 52;
  localparam int PA_NV_LOG2    = 4;
  localparam int PA_NUM_VOICES = 2 ** PA_NV_LOG2;

  // Sequencer states; IDLE is encoded as zero so a reset debug view reads 0.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } pa_state_e;

endpackage

// File: rtl/pa_sync_pend.sv
// Per-voice hard-sync pending register.
// A set request is visible on pend_eff in the same cycle (bypass), so a sync
// aimed at the slot currently being processed is applied immediately.
// Multiple sets before service collapse into one pending bit.
module pa_sync_pend
  import pa_sched_pkg::*;
#(
  parameter int NV_LOG2 = PA_NV_LOG2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      set_valid,
  input  logic [NV_LOG2-1:0]        set_idx,
  input  logic                      clr_valid,
  input  logic [NV_LOG2-1:0]        clr_idx,
  output logic [(2**NV_LOG2)-1:0]   pend_eff
);

  localparam int NV = 2 ** NV_LOG2;

  logic [NV-1:0] r_pend;
  logic [NV-1:0] w_set;
  logic [NV-1:0] w_clr;

  assign w_set    = set_valid ? (NV'(1) << set_idx) : '0;
  assign w_clr    = clr_valid ? (NV'(1) << clr_idx) : '0;
  assign pend_eff = r_pend | w_set;

  // Set wins into the register unless the same voice is serviced this cycle,
  // in which case the bypassed request has already been consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | w_set) & ~w_clr;
    end
  end

endmodule

// File: rtl/phase_accum_sched.sv
// Time-multiplexed sequencer for a 16 x 52-bit distributed-RAM phase
// accumulator bank. Each sample tick sweeps all voices, one per clock:
// read phase, add increment, write back, emit the new phase.
// Optional build macro PA_INIT_CLEAR_EN: after reset the INIT state writes
// zero to every RAM entry before the first sweep can start.
//
// Handshake: there is no back-pressure. sample_tick and sync_valid are
// single-cycle strobes sampled on every rising clk; phase_valid and done are
// single-cycle strobes that the consumer must take when asserted.
module phase_accum_sched
  import pa_sched_pkg::*;
#(
  parameter int ACC_W   = PA_ACC_W,
  parameter int NV_LOG2 = PA_NV_LOG2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_tick,
  output logic [NV_LOG2-1:0] inc_voice,
  input  logic [ACC_W-1:0]   inc_data,
  input  logic               sync_valid,
  input  logic [NV_LOG2-1:0] sync_voice,
  output logic [NV_LOG2-1:0] ram_addr,
  output logic               ram_we,
  output logic [ACC_W-1:0]   ram_din,
  input  logic [ACC_W-1:0]   ram_dout,
  output logic [ACC_W-1:0]   phase_out,
  output logic [NV_LOG2-1:0] phase_voice,
  output logic               phase_valid,
  output logic               phase_wrap,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [1:0]         dbg_state
);

  localparam int NV = 2 ** NV_LOG2;

`ifdef PA_INIT_CLEAR_EN
  localparam pa_state_e RST_STATE = ST_INIT;
`else
  localparam pa_state_e RST_STATE = ST_IDLE;
`endif

  pa_state_e           r_state;
  pa_state_e           w_next_state;
  logic [NV_LOG2-1:0]  r_vcnt;
  logic                r_tick_pend;
  logic [ACC_W-1:0]    r_phase_out;
  logic [NV_LOG2-1:0]  r_phase_voice;
  logic                r_phase_valid;
  logic                r_phase_wrap;
  logic                r_done;
  logic                r_overrun;

  logic                w_in_run;
  logic                w_in_init;
  logic                w_last;
  logic [ACC_W:0]      w_sum;
  logic [NV-1:0]       w_pend_eff;
  logic                w_sync_hit;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_in_init  = (r_state == ST_INIT);
  assign w_last     = (r_vcnt == NV_LOG2'(NV - 1));
  assign w_sum      = {1'b0, ram_dout} + {1'b0, inc_data};
  assign w_sync_hit = w_in_run && w_pend_eff[r_vcnt];

  pa_sync_pend #(
    .NV_LOG2 (NV_LOG2)
  ) u_sync_pend (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_valid (sync_valid),
    .set_idx   (sync_voice),
    .clr_valid (w_sync_hit),
    .clr_idx   (r_vcnt),
    .pend_eff  (w_pend_eff)
  );

  // RAM port: address follows the slot counter while sweeping or clearing,
  // parked at 0 otherwise; a synced slot writes zero instead of the sum.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (w_in_run) begin
      ram_addr = r_vcnt;
      ram_we   = 1'b1;
      ram_din  = w_sync_hit ? '0 : w_sum[ACC_W-1:0];
    end else if (w_in_init) begin
      ram_addr = r_vcnt;
      ram_we   = 1'b1;
    end
  end

  assign inc_voice   = ram_addr;
  assign busy        = (r_state != ST_IDLE);
  assign phase_out   = r_phase_out;
  assign phase_voice = r_phase_voice;
  assign phase_valid = r_phase_valid;
  assign phase_wrap  = r_phase_wrap;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

  // Next-state logic; a pended tick restarts the sweep from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (sample_tick || r_tick_pend) w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      ST_INIT: if (w_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Voice/address counter: advances once per RUN or INIT slot, 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vcnt <= '0;
    end else if (w_in_run || w_in_init) begin
      r_vcnt <= r_vcnt + NV_LOG2'(1);
    end else begin
      r_vcnt <= '0;
    end
  end

  // Tick bookkeeping: one tick may wait while busy, a further one is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= busy && sample_tick && r_tick_pend;
      if (!busy) begin
        r_tick_pend <= sample_tick && r_tick_pend;
      end else if (sample_tick) begin
        r_tick_pend <= 1'b1;
      end
    end
  end

  // Registered phase result; holds its last value between slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase_out   <= '0;
      r_phase_voice <= '0;
      r_phase_valid <= 1'b0;
      r_phase_wrap  <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_phase_valid <= w_in_run;
      r_done        <= (r_state == ST_DONE);
      if (w_in_run) begin
        r_phase_out   <= ram_din;
        r_phase_voice <= r_vcnt;
        r_phase_wrap  <= w_sum[ACC_W] && !w_sync_hit;
      end
    end
  end

endmodule

// File: tb/tb_phase_accum_sched.sv
// Bench for phase_accum_sched: behavioural RAM, sweep-timeline reference
// model, per-cycle compare, directed scenarios and a randomized phase.
module tb_phase_accum_sched;

  localparam int ACC_W   = 52;
  localparam int NV_LOG2 = 4;
  localparam int NV      = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               sample_tick = 1'b0;
  logic               sync_valid  = 1'b0;
  logic [NV_LOG2-1:0] sync_voice  = '0;
  logic [NV_LOG2-1:0] inc_voice, ram_addr, phase_voice;
  logic [ACC_W-1:0]   inc_data, ram_din, ram_dout, phase_out;
  logic               ram_we, phase_valid, phase_wrap, busy, done, overrun;
  logic [1:0]         dbg_state;

  phase_accum_sched dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .inc_voice(inc_voice), .inc_data(inc_data),
    .sync_valid(sync_valid), .sync_voice(sync_voice),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .phase_out(phase_out), .phase_voice(phase_voice), .phase_valid(phase_valid),
    .phase_wrap(phase_wrap), .busy(busy), .done(done), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural RAM (async read, sync write) ----------------
  logic [ACC_W-1:0] ram    [NV];
  logic [ACC_W-1:0] pl_img [NV];
  logic             pl_go = 1'b0;
  logic [ACC_W-1:0] inc_tab [NV];

  assign ram_dout = ram[ram_addr];
  assign inc_data = inc_tab[inc_voice];

  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < NV; i++) ram[i] <= pl_img[i];
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: a sweep starting at cycle s processes voice v in cycle s+v,
  // shows its result in s+v+1, is busy through s+16 and pulses done at s+17.
  logic [ACC_W-1:0]   m_ph [NV];
  bit   [NV-1:0]      m_sync;
  bit                 m_pend;
  int                 m_cyc = 0;
  int                 run_start = -1000;
  logic [ACC_W-1:0]   e_phase;
  logic [NV_LOG2-1:0] e_voice, e_addr;
  logic               e_valid, e_wrap, e_done, e_ovr, e_busy, e_we;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_start = -1000;
      m_pend = 0; m_sync = '0;
      e_phase = '0; e_voice = '0; e_addr = '0;
      e_valid = 0; e_wrap = 0; e_done = 0; e_ovr = 0; e_busy = 0; e_we = 0;
    end else begin
      int prev, slot, cur;
      bit hit, prev_busy;
      logic [ACC_W:0] s;
      prev = m_cyc;
      m_cyc++;
      slot = prev - run_start;
      prev_busy = (slot >= 0) && (slot <= 16);
      e_done = (slot == 16);
      e_valid = 0;
      hit = 0;
      if (slot >= 0 && slot < NV) begin
        hit = m_sync[slot] || (sync_valid && int'(sync_voice) == slot);
        s = {1'b0, m_ph[slot]} + {1'b0, inc_tab[slot]};
        m_ph[slot] = hit ? '0 : s[ACC_W-1:0];
        e_phase = m_ph[slot];
        e_voice = NV_LOG2'(slot);
        e_wrap  = hit ? 1'b0 : s[ACC_W];
        e_valid = 1;
      end
      if (sync_valid) m_sync[sync_voice] = 1'b1;
      if (hit) m_sync[slot] = 1'b0;
      e_ovr = 0;
      if (!prev_busy) begin
        if (sample_tick || m_pend) begin
          m_pend = sample_tick && m_pend;
          run_start = m_cyc;
        end
      end else if (sample_tick) begin
        if (m_pend) e_ovr = 1;
        else m_pend = 1;
      end
      cur = m_cyc - run_start;
      e_busy = (cur >= 0) && (cur <= 16);
      e_we   = (cur >= 0) && (cur < NV);
      e_addr = e_we ? NV_LOG2'(cur) : '0;
    end
  end

  // ---------------- monitor + per-cycle compare ----------------
  int               cyc_n = 0;
  int               n_valid = 0, n_done = 0, n_ovr = 0;
  int               first_valid = -1, first_voice = -1, done_cyc = -1;
  logic [ACC_W-1:0] cap_ph [NV];
  bit               cap_wrap [NV];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase_valid", 64'(phase_valid), 64'(e_valid));
      chk("phase_out",   64'(phase_out),   64'(e_phase));
      chk("phase_voice", 64'(phase_voice), 64'(e_voice));
      chk("phase_wrap",  64'(phase_wrap),  64'(e_wrap));
      chk("done",        64'(done),        64'(e_done));
      chk("overrun",     64'(overrun),     64'(e_ovr));
      chk("busy",        64'(busy),        64'(e_busy));
      chk("ram_we",      64'(ram_we),      64'(e_we));
      chk("ram_addr",    64'(ram_addr),    64'(e_addr));
      chk("inc_voice",   64'(inc_voice),   64'(e_addr));
    end
    if (phase_valid) begin
      n_valid++;
      cap_ph[phase_voice]   = phase_out;
      cap_wrap[phase_voice] = phase_wrap;
      if (first_valid < 0) begin
        first_valid = cyc_n;
        first_voice = int'(phase_voice);
      end
    end
    if (done) begin n_done++; done_cyc = cyc_n; end
    if (overrun) n_ovr++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) cyc();
  endtask

  task automatic load_ram();
    for (int i = 0; i < NV; i++) pl_img[i] = m_ph[i];
    pl_go = 1'b1;
    cyc();
    pl_go = 1'b0;
  endtask

  int t_tick;
  task automatic do_tick();
    t_tick = cyc_n;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int               nv0, nd0, no0, t5, nb;
  logic [ACC_W-1:0] snap [NV];
  logic [ACC_W-1:0] expv;
  logic [63:0]      r64;

  initial begin
    for (int i = 0; i < NV; i++) begin
      m_ph[i] = '0;
      inc_tab[i] = ACC_W'(i + 1);
    end
`ifdef PA_INIT_CLEAR_EN
    // INIT clear: RAM starts at 0xFFFF everywhere, a tick arrives during INIT.
    for (int i = 0; i < NV; i++) m_ph[i] = 52'hFFFF;
    load_ram();
    cyc();
    reset_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) sample_tick = 1'b1;
      if (i == 4) sample_tick = 1'b0;
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    sample_tick = 1'b0;
    chk("init_busy_cycles", 64'(nb), 64'd16);
    for (int i = 0; i < NV; i++) chk("init_ram_zero", 64'(ram[i]), 64'd0);
    first_valid = -1;
    wait_cyc(25);
    chk("init_tick_first_voice", 64'(first_voice), 64'd0);
    chk("init_tick_sweep_len", 64'(n_valid), 64'd16);
    chk("init_tick_phase0", 64'(cap_ph[0]), 64'd1);
`else
    load_ram();
    // Reset state.
    @(negedge clk);
    chk("rst_phase_valid", 64'(phase_valid), 64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_ram_we",      64'(ram_we),      64'd0);
    chk("rst_dbg_state",   64'(dbg_state),   64'd0);
    cyc();
    reset_n = 1'b1;
    chk_en = 1'b1;
    wait_cyc(3);

    // 1: RAM=0, inc=v+1, single tick.
    nv0 = n_valid; first_valid = -1;
    do_tick();
    wait_cyc(22);
    chk("t1_first_valid_lat", 64'(first_valid - t_tick), 64'd2);
    chk("t1_first_voice",     64'(first_voice), 64'd0);
    chk("t1_done_lat",        64'(done_cyc - t_tick), 64'd18);
    chk("t1_valid_count",     64'(n_valid - nv0), 64'd16);
    for (int v = 0; v < NV; v++) chk("t1_phase", 64'(cap_ph[v]), 64'(v + 1));

    // 2: wrap on voice 3.
    m_ph[3] = {ACC_W{1'b1}} - ACC_W'(1);
    inc_tab[3] = ACC_W'(5);
    load_ram();
    do_tick();
    wait_cyc(22);
    chk("t2_phase3", 64'(cap_ph[3]), 64'd3);
    chk("t2_wrap3",  64'(cap_wrap[3]), 64'd1);
    chk("t2_ram3",   64'(ram[3]), 64'd3);
    chk("t2_wrap2",  64'(cap_wrap[2]), 64'd0);

    // 3: sync 7 after its slot, sync 9 in its own slot.
    do_tick();
    wait_cyc(8);
    sync_valid = 1'b1; sync_voice = 4'd7;
    cyc();
    sync_voice = 4'd9;
    cyc();
    sync_valid = 1'b0; sync_voice = '0;
    wait_cyc(12);
    chk("t3_s1_phase9", 64'(cap_ph[9]), 64'd0);
    chk("t3_s1_wrap9",  64'(cap_wrap[9]), 64'd0);
    do_tick();
    wait_cyc(22);
    chk("t3_s2_phase7", 64'(cap_ph[7]), 64'd0);
    chk("t3_s2_wrap7",  64'(cap_wrap[7]), 64'd0);
    chk("t3_s2_phase9", 64'(cap_ph[9]), 64'd10);
    do_tick();
    wait_cyc(22);
    chk("t3_s3_phase7", 64'(cap_ph[7]), 64'd8);

    // 4: ticks at t0, t0+3, t0+5.
    nv0 = n_valid; nd0 = n_done; no0 = n_ovr;
    do_tick();
    wait_cyc(2);
    do_tick();
    wait_cyc(1);
    do_tick();
    wait_cyc(45);
    chk("t4_valid_count", 64'(n_valid - nv0), 64'd32);
    chk("t4_overruns",    64'(n_ovr - no0), 64'd1);
    chk("t4_dones",       64'(n_done - nd0), 64'd2);

    // 5: reset during slot 8.
    for (int i = 0; i < NV; i++) snap[i] = ram[i];
    nd0 = n_done;
    do_tick();
    wait_cyc(8);
    reset_n = 1'b0;
    #2;
    chk("t5_rst_valid",   64'(phase_valid), 64'd0);
    chk("t5_rst_out",     64'(phase_out),   64'd0);
    chk("t5_rst_busy",    64'(busy),        64'd0);
    chk("t5_rst_we",      64'(ram_we),      64'd0);
    chk("t5_rst_addr",    64'(ram_addr),    64'd0);
    chk("t5_rst_done",    64'(done),        64'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(25);
    chk("t5_no_done", 64'(n_done - nd0), 64'd0);
    for (int i = 0; i < NV; i++) begin
      expv = (i < 8) ? snap[i] + inc_tab[i] : snap[i];
      chk("t5_ram", 64'(ram[i]), 64'(expv));
    end
    first_valid = -1;
    do_tick();
    wait_cyc(22);
    chk("t5_restart_voice", 64'(first_voice), 64'd0);
    chk("t5_restart_lat",   64'(first_valid - t_tick), 64'd2);

    // Randomized ticks and syncs over random RAM / increments.
    for (int i = 0; i < NV; i++) begin
      r64 = {$urandom(), $urandom()};
      m_ph[i] = r64[ACC_W-1:0];
      r64 = {$urandom(), $urandom()};
      inc_tab[i] = r64[ACC_W-1:0];
    end
    inc_tab[0] = {ACC_W{1'b1}};
    load_ram();
    for (int c = 0; c < 900; c++) begin
      sample_tick = ($urandom_range(0, 11) == 0);
      sync_valid  = ($urandom_range(0, 5) == 0);
      sync_voice  = NV_LOG2'($urandom_range(0, NV - 1));
      cyc();
    end
    sample_tick = 1'b0; sync_valid = 1'b0; sync_voice = '0;
    wait_cyc(45);
    for (int i = 0; i < NV; i++) chk("rand_final_ram", 64'(ram[i]), 64'(m_ph[i]));
`endif
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
